// File: rtl/fft_sample_loader.sv
// Peripheral-mapped sample buffer for a 16-point radix-4 FFT stage.
// The CPU fills 16 complex samples, then START issues four decimated groups over a valid/ready port.

module fft_sample_loader #(
    parameter int          DW        = 16,
    parameter logic [13:0] BASE_ADDR = 14'h0080
) (
    input  logic          mclk,
    input  logic          puc_rst_n,

    input  logic [13:0]   per_addr,
    input  logic [15:0]   per_din,
    input  logic          per_en,
    input  logic [1:0]    per_we,
    output logic [15:0]   per_dout,

    output logic [DW-1:0] dout0r,
    output logic [DW-1:0] dout1r,
    output logic [DW-1:0] dout2r,
    output logic [DW-1:0] dout3r,
    output logic [DW-1:0] dout0i,
    output logic [DW-1:0] dout1i,
    output logic [DW-1:0] dout2i,
    output logic [DW-1:0] dout3i,
    output logic          bf_valid,
    input  logic          bf_ready,

    output logic          busy,
    output logic          done_irq
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_ISSUE   = 1'b1;

    localparam logic [5:0] OFF_CTRL   = 6'h20;
    localparam logic [5:0] OFF_STATUS = 6'h21;

    logic [0:0]    state;
    logic [1:0]    grp;
    logic          done_flag;

    logic [DW-1:0] re_mem [16];
    logic [DW-1:0] im_mem [16];
    logic [DW-1:0] dout_r [4];
    logic [DW-1:0] dout_i [4];

    logic          reg_sel;
    logic [5:0]    reg_off;
    logic [3:0]    reg_idx;
    logic          bus_wr;
    logic          bus_rd;
    logic          re_wr;
    logic          im_wr;
    logic          ctrl_wr;
    logic          start_acc;
    logic          done_clr;
    logic          xfer;
    logic          last_xfer;
    logic [1:0]    load_grp;

    function automatic logic [15:0] sext(input logic [DW-1:0] v);
        return 16'(signed'(v));
    endfunction

    // The block occupies a 64-word window, so only the upper address bits select it.
    assign reg_sel   = (per_addr[13:6] == BASE_ADDR[13:6]);
    assign reg_off   = per_addr[5:0];
    assign reg_idx   = reg_off[3:0];

    assign bus_wr    = per_en & (per_we == 2'b11) & reg_sel;
    assign bus_rd    = per_en & (per_we == 2'b00) & reg_sel;

    assign re_wr     = bus_wr & ~busy & (reg_off[5:4] == 2'b00);
    assign im_wr     = bus_wr & ~busy & (reg_off[5:4] == 2'b01);
    assign ctrl_wr   = bus_wr & (reg_off == OFF_CTRL);

    assign start_acc = ctrl_wr & per_din[0] & (state == ST_IDLE);
    assign done_clr  = ctrl_wr & per_din[1];

    assign xfer      = (state == ST_ISSUE) & bf_ready;
    assign last_xfer = xfer & (grp == 2'd3);

    // Group to present next: group 0 on START, otherwise the one after the accepted group.
    assign load_grp  = (state == ST_IDLE) ? 2'd0 : grp + 2'd1;

    // NOTE: the sample array is reset explicitly because a cleared buffer is required
    // after reset; this keeps it in flops rather than letting it map to a RAM.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            for (int k = 0; k < 16; k++) begin
                re_mem[k] <= '0;
                im_mem[k] <= '0;
            end
        end else begin
            if (re_wr) re_mem[reg_idx] <= per_din[DW-1:0];
            if (im_wr) im_mem[reg_idx] <= per_din[DW-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state <= ST_IDLE;
            grp   <= 2'd0;
            for (int j = 0; j < 4; j++) begin
                dout_r[j] <= '0;
                dout_i[j] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        state <= ST_ISSUE;
                        grp   <= 2'd0;
                    end
                end
                ST_ISSUE: begin
                    if (last_xfer) begin
                        state <= ST_IDLE;
                    end else if (xfer) begin
                        grp <= grp + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Lane j of group g carries sample g + 4*j, i.e. index {j, g}.
            if (start_acc || (xfer && !last_xfer)) begin
                for (int j = 0; j < 4; j++) begin
                    dout_r[j] <= re_mem[{2'(j), load_grp}];
                    dout_i[j] <= im_mem[{2'(j), load_grp}];
                end
            end
        end
    end

    // START clears, the final transfer sets (beating a simultaneous DONE_CLR).
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            done_flag <= 1'b0;
        end else if (start_acc) begin
            done_flag <= 1'b0;
        end else if (last_xfer) begin
            done_flag <= 1'b1;
        end else if (done_clr) begin
            done_flag <= 1'b0;
        end
    end

    // NOTE: per_dout gets a default before any branch so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        per_dout = 16'h0000;
        if (bus_rd) begin
            if (reg_off[5:4] == 2'b00) begin
                per_dout = sext(re_mem[reg_idx]);
            end else if (reg_off[5:4] == 2'b01) begin
                per_dout = sext(im_mem[reg_idx]);
            end else if (reg_off == OFF_STATUS) begin
                per_dout = {14'h0000, done_flag, busy};
            end
        end
    end

    assign busy     = (state == ST_ISSUE);
    assign bf_valid = (state == ST_ISSUE);
    assign done_irq = done_flag;

    assign dout0r   = dout_r[0];
    assign dout1r   = dout_r[1];
    assign dout2r   = dout_r[2];
    assign dout3r   = dout_r[3];
    assign dout0i   = dout_i[0];
    assign dout1i   = dout_i[1];
    assign dout2i   = dout_i[2];
    assign dout3i   = dout_i[3];

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: register table, directed corner sequences,
// and randomized sample/ready stimulus checked against an array-based model of the buffer.

module tb_fft_sample_loader;

    localparam int          DW   = 16;
    localparam logic [13:0] BASE = 14'h0080;

    logic          mclk;
    logic          puc_rst_n;
    logic [13:0]   per_addr;
    logic [15:0]   per_din;
    logic          per_en;
    logic [1:0]    per_we;
    logic [15:0]   per_dout;
    logic [DW-1:0] dout0r, dout1r, dout2r, dout3r;
    logic [DW-1:0] dout0i, dout1i, dout2i, dout3i;
    logic          bf_valid;
    logic          bf_ready;
    logic          busy;
    logic          done_irq;

    fft_sample_loader #(.DW(DW), .BASE_ADDR(BASE)) dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout),
        .dout0r    (dout0r),
        .dout1r    (dout1r),
        .dout2r    (dout2r),
        .dout3r    (dout3r),
        .dout0i    (dout0i),
        .dout1i    (dout1i),
        .dout2i    (dout2i),
        .dout3i    (dout3i),
        .bf_valid  (bf_valid),
        .bf_ready  (bf_ready),
        .busy      (busy),
        .done_irq  (done_irq)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic [DW-1:0] dr [4];
    logic [DW-1:0] di [4];
    assign dr[0] = dout0r; assign dr[1] = dout1r; assign dr[2] = dout2r; assign dr[3] = dout3r;
    assign di[0] = dout0i; assign di[1] = dout1i; assign di[2] = dout2i; assign di[3] = dout3i;

    // Transfer recorder: every accepted group is logged in arrival order.
    logic [15:0] obs_r [256][4];
    logic [15:0] obs_i [256][4];
    int          obs_cnt = 0;

    always @(posedge mclk) begin
        if (puc_rst_n && bf_valid && bf_ready) begin
            for (int j = 0; j < 4; j++) begin
                obs_r[obs_cnt[7:0]][j] <= dr[j];
                obs_i[obs_cnt[7:0]][j] <= di[j];
            end
            obs_cnt <= obs_cnt + 1;
        end
    end

    // Reference model of the sample buffer.
    logic [15:0] re_m [16];
    logic [15:0] im_m [16];
    bit          mdl_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_wr;
        logic [13:0] addr;
        logic        en;
        logic [1:0]  we;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic bus_write(input logic [5:0] off, input logic [15:0] d, input logic [1:0] we);
        per_addr = BASE | {8'h00, off};
        per_din  = d;
        per_we   = we;
        per_en   = 1'b1;
        cycle();
        per_en   = 1'b0;
        per_we   = 2'b00;
        if (we == 2'b11 && !mdl_busy && off < 6'h20) begin
            if (off < 6'h10) re_m[off[3:0]] = d;
            else             im_m[off[3:0]] = d;
        end
    endtask

    task automatic bus_read(input logic [5:0] off, output logic [15:0] d);
        per_addr = BASE | {8'h00, off};
        per_we   = 2'b00;
        per_en   = 1'b1;
        #1;
        d        = per_dout;
        per_en   = 1'b0;
    endtask

    task automatic wr_sample(input int k, input logic [15:0] re, input logic [15:0] im);
        bus_write(6'(k), re, 2'b11);
        bus_write(6'(16 + k), im, 2'b11);
    endtask

    task automatic check_groups(input int base, input int n);
        check("xfer_count", obs_cnt - base, n);
        for (int t = 0; t < n; t++) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("grp%0d_re%0d", t, j), obs_r[(base + t) % 256][j], re_m[t + 4 * j]);
                check($sformatf("grp%0d_im%0d", t, j), obs_i[(base + t) % 256][j], im_m[t + 4 * j]);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cycle();
            n++;
        end
        check("idle_within_budget", busy, 0);
    endtask

    // mode 0: ready always high; 1: three stall cycles per group; 2: random ready.
    task automatic issue(input int mode);
        int          base;
        int          k;
        bit          prev_rdy;
        logic [15:0] snap_r [4];
        logic [15:0] snap_i [4];
        base     = obs_cnt;
        bf_ready = 1'b0;
        bus_write(6'h20, 16'h0001, 2'b11);
        mdl_busy = 1'b1;
        check("start_valid", bf_valid, 1);
        prev_rdy = 1'b1;
        k        = 0;
        while (busy && k < 400) begin
            if (mode == 1 && !prev_rdy) begin
                check("stall_valid", bf_valid, 1);
                for (int j = 0; j < 4; j++) begin
                    check($sformatf("stall_re%0d", j), dr[j], snap_r[j]);
                    check($sformatf("stall_im%0d", j), di[j], snap_i[j]);
                end
            end
            for (int j = 0; j < 4; j++) begin
                snap_r[j] = dr[j];
                snap_i[j] = di[j];
            end
            case (mode)
                0:       bf_ready = 1'b1;
                1:       bf_ready = (k % 4 == 3);
                default: bf_ready = 1'($urandom_range(0, 1));
            endcase
            prev_rdy = bf_ready;
            cycle();
            k++;
        end
        bf_ready = 1'b0;
        mdl_busy = 1'b0;
        check("seq_terminated", busy, 0);
        check("seq_done", done_irq, 1);
        check_groups(base, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        int          base;

        puc_rst_n = 1'b0;
        per_addr  = '0;
        per_din   = '0;
        per_en    = 1'b0;
        per_we    = 2'b00;
        bf_ready  = 1'b0;
        mdl_busy  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            re_m[k] = '0;
            im_m[k] = '0;
        end
        repeat (3) @(negedge mclk);
        puc_rst_n = 1'b1;
        cycle();

        // Reset state
        check("rst_bf_valid", bf_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_irq, 0);
        check("rst_dout0r", dout0r, 0);
        check("rst_dout3i", dout3i, 0);
        bus_read(6'h21, rd); check("rst_status", rd, 16'h0000);
        bus_read(6'h03, rd); check("rst_re3", rd, 16'h0000);

        // Register map table
        vecs.push_back('{1'b1, 14'h0080, 1'b1, 2'b11, 16'h1111, 16'h0000});
        vecs.push_back('{1'b0, 14'h0080, 1'b1, 2'b00, 16'h0000, 16'h1111});
        vecs.push_back('{1'b1, 14'h0080, 1'b1, 2'b01, 16'hFFFF, 16'h0000});
        vecs.push_back('{1'b0, 14'h0080, 1'b1, 2'b00, 16'h0000, 16'h1111});
        vecs.push_back('{1'b1, 14'h0080, 1'b1, 2'b10, 16'hFFFF, 16'h0000});
        vecs.push_back('{1'b0, 14'h0080, 1'b1, 2'b00, 16'h0000, 16'h1111});
        vecs.push_back('{1'b1, 14'h009F, 1'b1, 2'b11, 16'hABCD, 16'h0000});
        vecs.push_back('{1'b0, 14'h009F, 1'b1, 2'b00, 16'h0000, 16'hABCD});
        vecs.push_back('{1'b0, 14'h00A5, 1'b1, 2'b00, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 14'h00A0, 1'b1, 2'b00, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 14'h00A1, 1'b1, 2'b00, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 14'h0080, 1'b0, 2'b00, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 14'h0080, 1'b1, 2'b01, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 14'h0040, 1'b1, 2'b00, 16'h0000, 16'h0000});
        vecs.push_back('{1'b1, 14'h0040, 1'b1, 2'b11, 16'h5555, 16'h0000});
        vecs.push_back('{1'b0, 14'h0080, 1'b1, 2'b00, 16'h0000, 16'h1111});
        vecs.push_back('{1'b0, 14'h0090, 1'b1, 2'b00, 16'h0000, 16'h0000});
        vecs.push_back('{1'b1, 14'h0085, 1'b1, 2'b11, 16'h8000, 16'h0000});
        vecs.push_back('{1'b0, 14'h0085, 1'b1, 2'b00, 16'h0000, 16'h8000});
        for (int i = 0; i < vecs.size(); i++) begin
            per_addr = vecs[i].addr;
            per_din  = vecs[i].din;
            per_en   = vecs[i].en;
            per_we   = vecs[i].we;
            if (vecs[i].is_wr) begin
                cycle();
            end else begin
                #1;
                check($sformatf("vec%0d_read", i), per_dout, vecs[i].exp);
            end
            per_en = 1'b0;
            per_we = 2'b00;
        end

        // Ramp data, ready held high: exact cycle timing of the four transfers
        for (int k = 0; k < 16; k++) wr_sample(k, 16'(k), 16'(-k));
        base     = obs_cnt;
        bf_ready = 1'b1;
        bus_write(6'h20, 16'h0001, 2'b11);
        mdl_busy = 1'b1;
        check("t1_valid_e0", bf_valid, 1);
        check("t1_busy_e0", busy, 1);
        check("t1_g0_lane0", dout0r, 16'd0);
        check("t1_g0_lane1", dout1r, 16'd4);
        check("t1_g0_lane2", dout2r, 16'd8);
        check("t1_g0_lane3", dout3r, 16'd12);
        check("t1_g0_im3", dout3i, 16'hFFF4);
        cycle();
        check("t1_g1_lane0", dout0r, 16'd1);
        cycle();
        cycle();
        check("t1_g3_lane3", dout3r, 16'd15);
        check("t1_done_e3", done_irq, 0);
        check("t1_busy_e3", busy, 1);
        cycle();
        check("t1_done_e4", done_irq, 1);
        check("t1_busy_e4", busy, 0);
        check("t1_valid_e4", bf_valid, 0);
        bf_ready = 1'b0;
        mdl_busy = 1'b0;
        bus_read(6'h21, rd); check("t1_status", rd, 16'h0002);
        check_groups(base, 4);

        // Three stall cycles on every group
        issue(1);

        // Writes and START while busy are ignored
        base     = obs_cnt;
        bf_ready = 1'b0;
        bus_write(6'h20, 16'h0001, 2'b11);
        mdl_busy = 1'b1;
        bus_write(6'h05, 16'h1234, 2'b11);
        bus_write(6'h20, 16'h0001, 2'b11);
        bf_ready = 1'b1;
        cycle();
        bf_ready = 1'b0;
        bus_write(6'h20, 16'h0001, 2'b11);
        check("t3_one_xfer", obs_cnt - base, 1);
        check("t3_still_g1", dout0r, re_m[1]);
        bus_read(6'h05, rd); check("t3_re5_kept", rd, re_m[5]);
        bf_ready = 1'b1;
        wait_idle(20);
        bf_ready = 1'b0;
        mdl_busy = 1'b0;
        check("t3_done", done_irq, 1);
        check_groups(base, 4);

        // START together with DONE_CLR, then DONE_CLR on the final-transfer edge
        check("t6_pre_done", done_irq, 1);
        base     = obs_cnt;
        bus_write(6'h20, 16'h0003, 2'b11);
        mdl_busy = 1'b1;
        check("t6_start_wins", done_irq, 0);
        check("t6_busy", busy, 1);
        bf_ready = 1'b1;
        repeat (3) cycle();
        check("t6_done_before_last", done_irq, 0);
        bus_write(6'h20, 16'h0002, 2'b11);
        check("t6_set_wins", done_irq, 1);
        check("t6_idle", busy, 0);
        repeat (3) cycle();
        check("t6_ready_idle_noop", obs_cnt - base, 4);
        check("t6_sticky", done_irq, 1);
        bf_ready = 1'b0;
        mdl_busy = 1'b0;
        check_groups(base, 4);
        bus_write(6'h20, 16'h0002, 2'b11);
        check("t6_clr", done_irq, 0);
        bus_read(6'h21, rd); check("t6_status", rd, 16'h0000);

        // Randomized samples and ready pattern
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 16; k++) wr_sample(k, 16'($urandom), 16'($urandom));
            for (int q = 0; q < 4; q++) begin
                int k = $urandom_range(0, 31);
                bus_read(6'(k), rd);
                check("rand_read", rd, (k < 16) ? re_m[k] : im_m[k - 16]);
            end
            issue((r == 0) ? 0 : 2);
        end

        // Reset after the second transfer
        base     = obs_cnt;
        bf_ready = 1'b0;
        bus_write(6'h20, 16'h0001, 2'b11);
        mdl_busy = 1'b1;
        bf_ready = 1'b1;
        repeat (2) cycle();
        bf_ready = 1'b0;
        check_groups(base, 2);
        puc_rst_n = 1'b0;
        #1;
        check("t5_valid", bf_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done_irq, 0);
        check("t5_dout1r", dout1r, 0);
        check("t5_dout2i", dout2i, 0);
        for (int k = 0; k < 16; k++) re_m[k] = '0;
        for (int k = 0; k < 16; k++) im_m[k] = '0;
        mdl_busy = 1'b0;
        for (int k = 0; k < 32; k += 5) begin
            bus_read(6'(k), rd);
            check($sformatf("t5_mem%0d", k), rd, 16'h0000);
        end
        @(negedge mclk);
        bf_ready  = 1'b1;
        cycle();
        puc_rst_n = 1'b1;
        repeat (8) cycle();
        check("t5_no_activity", obs_cnt - base, 2);
        check("t5_post_busy", busy, 0);
        check("t5_post_valid", bf_valid, 0);
        check("t5_post_done", done_irq, 0);
        bf_ready = 1'b0;

        // Restart after reset
        for (int k = 0; k < 16; k++) wr_sample(k, 16'($urandom), 16'($urandom));
        issue(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
